// File: rtl/ke_pkg.sv
// Shared constants, types and S-box arithmetic for the AES-128 key-schedule controller.
package ke_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int EXP_W = 1408;

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef logic [127:0] rkey_t;

    typedef enum logic {IDLE, RUN} ke_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which also maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        logic [7:0] e;
        r  = 8'h01;
        sq = a;
        e  = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/ke_core.sv
// One AES-128 key-expansion round: derives round key r from round key r-1 and round number r.
module ke_core
    import ke_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   round,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [7:0]  rcon;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    always_comb begin
        rcon = 8'h00;
        case (round)
            8'd1:  rcon = 8'h01;
            8'd2:  rcon = 8'h02;
            8'd3:  rcon = 8'h04;
            8'd4:  rcon = 8'h08;
            8'd5:  rcon = 8'h10;
            8'd6:  rcon = 8'h20;
            8'd7:  rcon = 8'h40;
            8'd8:  rcon = 8'h80;
            8'd9:  rcon = 8'h1b;
            8'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp = sub ^ {rcon, 24'h000000};

    logic [31:0] n0, n1, n2, n3;
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/ke_sched.sv
// Sequential AES-128 key schedule: one shared ke_core, one round per cycle, 11-entry key file.
// Optional KE_SCHED_ZEROIZE_EN adds a zeroize input that wipes all key material.
module ke_sched
    import ke_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [127:0]  key,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [3:0]    rk_idx,
    output logic [127:0]  rk,
`ifdef KE_SCHED_ZEROIZE_EN
    input  logic          zeroize,
`endif
    output logic [1407:0] expanded
);

    ke_state_t state, next_state;
    logic [3:0] rnd;
    rkey_t      rk_file [0:NR];
    rkey_t      core_in;
    rkey_t      core_out;
    logic       clear;

`ifdef KE_SCHED_ZEROIZE_EN
    assign clear = zeroize;
`else
    assign clear = 1'b0;
`endif

    // rnd is 0 only outside RUN; the core input is then a don't-care.
    assign core_in = (rnd == 4'd0) ? '0 : rk_file[rnd - 4'd1];

    ke_core u_core (
        .prev_key (core_in),
        .round    ({4'b0000, rnd}),
        .next_key (core_out)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (rnd == LAST_RND) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk         <= '0;
            for (int i = 0; i <= NR; i++) rk_file[i] <= '0;
        end else if (clear) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk         <= '0;
            for (int i = 0; i <= NR; i++) rk_file[i] <= '0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            rk    <= (rk_idx <= LAST_RND) ? rk_file[rk_idx] : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_file[0] <= key;
                        rnd        <= 4'd1;
                        keys_valid <= 1'b0;
                    end
                end
                RUN: begin
                    rk_file[rnd] <= core_out;
                    if (rnd == LAST_RND) begin
                        rnd        <= 4'd0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // rk0 occupies the most significant slice, rk10 the least.
    genvar g;
    generate
        for (g = 0; g <= NR; g++) begin : g_exp
            assign expanded[EXP_W-1-KEY_W*g -: KEY_W] = rk_file[g];
        end
    endgenerate

endmodule
